// File: rtl/norm_frame_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : norm_frame_ctrl_if
// Purpose  : Host register bus for norm_frame_ctrl (address, write strobe and
//            data, read strobe, registered read data).
// Revision : 1.0 - initial release
// ============================================================================
interface norm_frame_ctrl_if;
  logic [3:0]  addr_rel_i;
  logic        wr_i;
  logic [31:0] datawr_i;
  logic        rd_i;
  logic [31:0] datard_o;

  // Host side drives the request, controller returns read data
  modport master (output addr_rel_i, output wr_i, output datawr_i,
                  output rd_i, input datard_o);
  modport slave  (input addr_rel_i, input wr_i, input datawr_i,
                  input rd_i, output datard_o);
endinterface
`default_nettype wire

// File: rtl/norm_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : norm_frame_ctrl
// Purpose  : Frame gate in front of normhw (enable, decimation, single shot)
//            and a write queue that replays normhw register writes only while
//            the stream is in vertical blank.
// Revision : 1.0 - initial release
// ============================================================================
module norm_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NORM_AW    = 4
) (
  input  logic                  clk_proc,
  input  logic                  reset_n,
  input  logic                  in_fv,
  input  logic                  in_dv,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_fv,
  output logic                  out_dv,
  output logic [DATA_WIDTH-1:0] out_data,
  norm_frame_ctrl_if.slave      host,
  output logic [NORM_AW-1:0]    norm_addr_o,
  output logic                  norm_wr_o,
  output logic [31:0]           norm_data_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Host-visible registers
  logic               ctrl_en;
  logic               ctrl_ss;
  logic [7:0]         decim;
  logic [NORM_AW-1:0] stage_addr;
  logic [31:0]        stage_data;
  logic               overflow;
  logic [31:0]        rd_data;
  logic [31:0]        rd_mux;

  // Frame tracking
  logic        prev_fv;
  logic        pass;
  logic [7:0]  skip_cnt;
  logic [15:0] frame_cnt;

  // Pending normhw writes
  logic [NORM_AW+31:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic [PTR_W:0]      fifo_count;
  logic                fifo_empty;
  logic                fifo_full;

  logic frame_start;
  logic frame_end;
  logic start_pass;
  logic pass_now;
  logic decim_wr;
  logic push_req;
  logic push;
  logic pop;

  assign frame_start = in_fv & ~prev_fv;
  assign frame_end   = ~in_fv & prev_fv & pass;
  assign start_pass  = ctrl_en & (skip_cnt == 8'd0);
  assign pass_now    = frame_start ? start_pass : pass;

  assign decim_wr    = host.wr_i & (host.addr_rel_i == 4'd1);
  assign push_req    = host.wr_i & (host.addr_rel_i == 4'd4);

  assign fifo_count  = wr_ptr - rd_ptr;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // Fullness is judged on the pre-pop state, so a same-cycle pop never frees room
  assign push        = push_req & ~fifo_full;
  // Replay only when both the input and the delayed output stream are idle
  assign pop         = ~fifo_empty & ~in_fv & ~out_fv;

  assign host.datard_o = rd_data;

  // Read data selection for the host register map
  always_comb begin
    rd_mux = 32'd0;
    case (host.addr_rel_i)
      4'd0: rd_mux = {30'd0, ctrl_ss, ctrl_en};
      4'd1: rd_mux = {24'd0, decim};
      4'd2: rd_mux = {13'd0, overflow, pass, ~fifo_empty, frame_cnt};
      4'd3: rd_mux = {{(32-NORM_AW){1'b0}}, stage_addr};
      4'd4: rd_mux = stage_data;
      4'd5: rd_mux = {{(31-PTR_W){1'b0}}, fifo_count};
      default: rd_mux = 32'd0;
    endcase
  end

  // Host register writes, registered reads and overflow sticky flag
  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en    <= 1'b0;
      ctrl_ss    <= 1'b0;
      decim      <= 8'd0;
      stage_addr <= '0;
      stage_data <= 32'd0;
      overflow   <= 1'b0;
      rd_data    <= 32'd0;
    end else begin
      if (host.wr_i) begin
        case (host.addr_rel_i)
          4'd0: begin
            ctrl_en <= host.datawr_i[0];
            ctrl_ss <= host.datawr_i[1];
          end
          4'd1: decim      <= host.datawr_i[7:0];
          4'd3: stage_addr <= host.datawr_i[NORM_AW-1:0];
          4'd4: stage_data <= host.datawr_i;
          default: ;
        endcase
      end
      // A completed single-shot frame disarms the gate
      if (frame_end && ctrl_ss) ctrl_en <= 1'b0;
      if (host.rd_i) rd_data <= rd_mux;
      // Clear-on-read of STATUS; a new overflow in the same cycle takes priority
      if (host.rd_i && host.addr_rel_i == 4'd2) overflow <= 1'b0;
      if (push_req && fifo_full) overflow <= 1'b1;
    end
  end

  // Frame start/end detection, pass latch, decimation and frame counting
  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      prev_fv   <= 1'b1;  // drop a frame already running at reset release
      pass      <= 1'b0;
      skip_cnt  <= 8'd0;
      frame_cnt <= 16'd0;
    end else begin
      prev_fv <= in_fv;
      if (frame_start) begin
        pass <= start_pass;
        if (start_pass)              skip_cnt <= decim;
        else if (skip_cnt != 8'd0)   skip_cnt <= skip_cnt - 8'd1;
      end
      if (decim_wr)  skip_cnt  <= 8'd0;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Gated stream towards normhw, one cycle behind the input
  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      out_fv   <= 1'b0;
      out_dv   <= 1'b0;
      out_data <= '0;
    end else begin
      out_fv <= in_fv & pass_now;
      out_dv <= in_fv & in_dv & pass_now;
      if (in_fv && in_dv && pass_now) out_data <= in_data;
    end
  end

  // Queue storage; flushing is done through the pointers
  always_ff @(posedge clk_proc) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {stage_addr, host.datawr_i};
  end

  // Queue pointers and replay of the head entry onto the normhw slave port
  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      norm_wr_o   <= 1'b0;
      norm_addr_o <= '0;
      norm_data_o <= 32'd0;
    end else begin
      norm_wr_o <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {norm_addr_o, norm_data_o} <= fifo_mem[rd_ptr[PTR_W-1:0]];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_norm_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_norm_frame_ctrl
// Purpose  : Self-checking bench for norm_frame_ctrl with scoreboards for the
//            gated pixel stream and the replayed normhw writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_frame_ctrl;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int AW = 4;

  logic          clk_proc = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_fv    = 1'b0;
  logic          in_dv    = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          out_fv;
  logic          out_dv;
  logic [DW-1:0] out_data;
  logic [AW-1:0] norm_addr_o;
  logic          norm_wr_o;
  logic [31:0]   norm_data_o;

  norm_frame_ctrl_if host_if ();

  norm_frame_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .NORM_AW(AW)) dut (
    .clk_proc    (clk_proc),
    .reset_n     (reset_n),
    .in_fv       (in_fv),
    .in_dv       (in_dv),
    .in_data     (in_data),
    .out_fv      (out_fv),
    .out_dv      (out_dv),
    .out_data    (out_data),
    .host        (host_if.slave),
    .norm_addr_o (norm_addr_o),
    .norm_wr_o   (norm_wr_o),
    .norm_data_o (norm_data_o)
  );

  always #5 clk_proc = ~clk_proc;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int nw_cnt = 0;

  logic [DW-1:0]   sb_data [$];
  logic [AW+31:0]  sb_norm [$];

  // One clock: sample outputs on the falling edge, then return just after the rising edge
  task automatic step();
    logic [DW-1:0]  exp_d;
    logic [AW+31:0] exp_n;
    @(negedge clk_proc);
    if (out_fv === 1'b1) fv_cnt++;
    if (out_dv === 1'b1) begin
      checks++;
      if (sb_data.size() == 0) begin
        errors++;
        $display("FAIL out_dv_unexpected: out_data=%h but no pixel was expected", out_data);
      end else begin
        exp_d = sb_data.pop_front();
        if (out_data !== exp_d) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data, exp_d);
        end
      end
    end
    if (norm_wr_o === 1'b1) begin
      nw_cnt++;
      checks++;
      if (out_fv !== 1'b0) begin
        errors++;
        $display("FAIL norm_wr_overlap: out_fv=%b expected 0 during norm_wr_o", out_fv);
      end
      checks++;
      if (sb_norm.size() == 0) begin
        errors++;
        $display("FAIL norm_wr_unexpected: addr=%h data=%h but no write was queued", norm_addr_o, norm_data_o);
      end else begin
        exp_n = sb_norm.pop_front();
        if ({norm_addr_o, norm_data_o} !== exp_n) begin
          errors++;
          $display("FAIL norm_write: got addr=%h data=%h expected addr=%h data=%h",
                   norm_addr_o, norm_data_o, exp_n[AW+31:32], exp_n[31:0]);
        end
      end
    end
    @(posedge clk_proc);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    host_if.addr_rel_i = a;
    host_if.datawr_i   = d;
    host_if.wr_i       = 1'b1;
    step();
    host_if.wr_i       = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    host_if.addr_rel_i = a;
    host_if.rd_i       = 1'b1;
    step();
    host_if.rd_i       = 1'b0;
    d = host_if.datard_o;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_fv = 1'b0;
    in_dv = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    sb_data.delete();
    sb_norm.delete();
    step();
  endtask

  // Drive one frame of random-dv pixels, optionally with a host write at pixel wr_at
  task automatic send_frame(input bit pass_exp, input int npix, input int wr_at,
                            input logic [3:0] wa, input logic [31:0] wd);
    fv_cnt = 0;
    for (int i = 0; i < npix; i++) begin
      in_fv   = 1'b1;
      in_dv   = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      if (pass_exp && in_dv) sb_data.push_back(in_data);
      if (i == wr_at) begin
        host_if.addr_rel_i = wa;
        host_if.datawr_i   = wd;
        host_if.wr_i       = 1'b1;
      end else begin
        host_if.wr_i       = 1'b0;
      end
      step();
    end
    host_if.wr_i = 1'b0;
    in_fv = 1'b0;
    in_dv = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (fv_cnt != (pass_exp ? npix : 0)) begin
      errors++;
      $display("FAIL frame_fv_len: out_fv cycles=%0d expected %0d", fv_cnt, pass_exp ? npix : 0);
    end
    checks++;
    if (sb_data.size() != 0) begin
      errors++;
      $display("FAIL frame_pixels_missing: %0d expected pixels not seen", sb_data.size());
      sb_data.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({out_fv, out_dv, norm_wr_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: fv/dv/wr=%b expected 000", {out_fv, out_dv, norm_wr_o});
    end
    checks++;
    if (out_data !== '0 || norm_addr_o !== '0 || norm_data_o !== 32'd0 || host_if.datard_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_buses: out_data=%h naddr=%h ndata=%h rd=%h expected all 0",
               out_data, norm_addr_o, norm_data_o, host_if.datard_o);
    end
    reset_n = 1'b1;
    step();
    host_read(4'd2, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
    host_read(4'd5, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_fifo_count: got %h expected 0", rd); end
    // Start a passing frame, then hit reset asynchronously in the middle of it
    host_write(4'd0, 32'd1);
    in_fv = 1'b1;
    step();
    step();
    checks++;
    if (out_fv !== 1'b1) begin errors++; $display("FAIL pre_reset_fv: out_fv=%b expected 1", out_fv); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_fv !== 1'b0 || out_dv !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_fv=%b out_dv=%b expected 0 0", out_fv, out_dv);
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    host_read(4'd0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL ctrl_after_reset: got %h expected 0", rd); end
    host_write(4'd0, 32'd1);
    fv_cnt = 0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (fv_cnt != 0) begin errors++; $display("FAIL dropped_frame: out_fv cycles=%0d expected 0", fv_cnt); end
    in_fv = 1'b0;
    step();
    step();
    send_frame(1'b1, 8, -1, 4'd0, 32'd0);
  endtask

  task automatic test_decimation();
    logic [31:0] rd;
    do_reset();
    host_write(4'd0, 32'd1);
    host_write(4'd1, 32'd2);
    for (int f = 1; f <= 7; f++) send_frame((f % 3) == 1, 10, -1, 4'd0, 32'd0);
    host_read(4'd2, rd);
    checks++;
    if ((rd & 32'h0005_FFFF) !== 32'h0000_0003) begin
      errors++;
      $display("FAIL decim_status: got %h expected frames=3, fifo/overflow bits 0", rd);
    end
  endtask

  task automatic test_single_shot();
    logic [31:0] rd;
    host_write(4'd1, 32'd0);
    host_write(4'd0, 32'd3);
    send_frame(1'b1, 6, -1, 4'd0, 32'd0);
    host_read(4'd0, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL single_shot_ctrl: got %h expected 2", rd); end
    send_frame(1'b0, 6, -1, 4'd0, 32'd0);
    send_frame(1'b0, 6, -1, 4'd0, 32'd0);
    host_read(4'd2, rd);
    checks++;
    if (rd[15:0] !== 16'd4) begin errors++; $display("FAIL single_shot_frames: got %0d expected 4", rd[15:0]); end
  endtask

  task automatic test_fifo_replay();
    logic [31:0] rd;
    host_write(4'd0, 32'd1);
    nw_cnt = 0;
    in_fv = 1'b1;
    step();
    host_write(4'd3, 32'd2);
    host_write(4'd4, 32'h1234);
    sb_norm.push_back({4'd2, 32'h1234});
    host_write(4'd3, 32'd5);
    host_write(4'd4, 32'hABCD);
    sb_norm.push_back({4'd5, 32'hABCD});
    host_read(4'd5, rd);
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL replay_count_pending: got %0d expected 2", rd); end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (nw_cnt != 0) begin errors++; $display("FAIL replay_midframe: writes=%0d expected 0", nw_cnt); end
    in_fv = 1'b0;
    step();
    step();
    checks++;
    if (nw_cnt != 0) begin errors++; $display("FAIL replay_early: writes=%0d expected 0", nw_cnt); end
    step();
    step();
    checks++;
    if (nw_cnt != 2) begin errors++; $display("FAIL replay_burst: writes=%0d expected 2 back-to-back", nw_cnt); end
    step();
    host_read(4'd5, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL replay_count_after: got %0d expected 0", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    nw_cnt = 0;
    in_fv = 1'b1;
    step();
    host_write(4'd3, 32'd1);
    for (int k = 0; k < 5; k++) begin
      host_write(4'd4, 32'h100 + 32'(k));
      if (k < FD) sb_norm.push_back({4'd1, 32'h100 + 32'(k)});
    end
    host_read(4'd5, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL overflow_count: got %0d expected 4", rd); end
    host_read(4'd2, rd);
    checks++;
    if (rd[18] !== 1'b1 || rd[16] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b nonempty=%b expected 1 1", rd[18], rd[16]);
    end
    host_read(4'd2, rd);
    checks++;
    if (rd[18] !== 1'b0) begin errors++; $display("FAIL overflow_clear: ovf=%b expected 0", rd[18]); end
    in_fv = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (nw_cnt != 4 || sb_norm.size() != 0) begin
      errors++;
      $display("FAIL overflow_replay: writes=%0d pending=%0d expected 4 0", nw_cnt, sb_norm.size());
    end
  endtask

  task automatic test_enable_midframe();
    logic [31:0] rd;
    host_write(4'd0, 32'd1);
    step();
    send_frame(1'b1, 10, 4, 4'd0, 32'd0);
    send_frame(1'b0, 10, -1, 4'd0, 32'd0);
    host_read(4'd0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL enable_off_ctrl: got %h expected 0", rd); end
  endtask

  initial begin
    host_if.addr_rel_i = 4'd0;
    host_if.wr_i       = 1'b0;
    host_if.datawr_i   = 32'd0;
    host_if.rd_i       = 1'b0;
    test_reset();
    test_decimation();
    test_single_shot();
    test_fifo_replay();
    test_overflow();
    test_enable_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/norm_frame_ctrl.md
Name: norm_frame_ctrl

Overview:
- Frame-level controller placed in front of normhw on the clk_proc domain.
- Gates whole frames of the fv/dv/data stream into normhw, with enable, 1-of-(N+1) decimation and single-shot capture.
- Queues register writes destined for normhw and replays them on normhw's slave port only during vertical blank, so configuration never changes mid-frame.
- Has its own register slave port for host access.

Parameters:
- DATA_WIDTH, 16: pixel width.
- FIFO_DEPTH, 4: pending normhw write queue depth (power of 2).
- NORM_AW, 4: normhw register address width.

Ports:
- clk_proc  in  1  processing clock
- reset_n  in  1  reset; one clock; asynchronous, active-low
- in_fv  in  1  input frame valid
- in_dv  in  1  input data valid
- in_data  in  DATA_WIDTH  input pixel
- out_fv  out  1  gated frame valid to normhw
- out_dv  out  1  gated data valid to normhw
- out_data  out  DATA_WIDTH  gated pixel to normhw
- addr_rel_i  in  4  host register address
- wr_i  in  1  host write strobe
- datawr_i  in  32  host write data
- rd_i  in  1  host read strobe
- datard_o  out  32  host read data
- norm_addr_o  out  NORM_AW  normhw addr_rel_i
- norm_wr_o  out  1  normhw wr_i pulse
- norm_data_o  out  32  normhw datawr_i

Behaviour:
- Reset values:
  - All outputs 0.
  - CTRL, DECIM, STAGE_ADDR, STAGE_DATA = 0; skip_cnt = 0; FIFO empty; overflow = 0; frame counter = 0; pass flag = 0.
  - prev_fv resets to 1, so a frame already in progress at reset release is dropped entirely.
- Register map (write on wr_i; read registered, datard_o valid the cycle after rd_i):
  - 0 CTRL: bit0 enable, bit1 single_shot.
  - 1 DECIM: [7:0]. Any write also clears skip_cnt to 0.
  - 2 STATUS (RO): [15:0] frames passed, bit16 FIFO non-empty, bit17 pass flag, bit18 overflow. A read clears overflow, on the cycle after rd_i.
  - 3 STAGE_ADDR: [NORM_AW-1:0].
  - 4 STAGE_DATA: a write pushes {STAGE_ADDR, datawr_i} into the FIFO.
  - 5 FIFO count (RO).
  - Unmapped reads return 0; unmapped writes are ignored.
- Frame start: the cycle where in_fv=1 and prev_fv=0.
  - If enable=1 and skip_cnt=0: set pass=1 and load skip_cnt=DECIM.
  - Else: pass=0, and skip_cnt decrements if non-zero.
  - The pass decision is latched for the whole frame. CTRL/DECIM writes mid-frame affect the next frame only.
- Stream path (1-cycle latency, all registered):
  - out_fv <= in_fv & pass_now, where pass_now is the frame-start decision on the start cycle, else the latched pass.
  - out_dv <= in_fv & in_dv & pass_now.
  - out_data <= in_data when out_dv is being set; otherwise it holds.
  - Blocked frames produce no out_fv at all.
- Frame end: in_fv=1→0 while pass=1.
  - Frame counter increments, wrapping at 16 bits.
  - If single_shot=1, enable clears on that cycle.
- Config replay:
  - Condition: FIFO non-empty, in_fv=0 and out_fv=0 in the current cycle.
  - Next cycle: norm_wr_o=1 for one cycle with norm_addr_o/norm_data_o from the FIFO head, and the head is popped. One write per cycle while the condition holds.
  - When not writing, norm_wr_o=0 and addr/data hold.
- Guaranteed: norm_wr_o never coincides with out_fv=1, since out_fv lags in_fv by one cycle.
- FIFO full:
  - A push is dropped and overflow is set.
  - Fullness is evaluated before a same-cycle pop, so a push into a full FIFO is dropped even if a pop occurs that cycle.
  - Push and pop in the same cycle on a non-full FIFO both succeed.
- Asynchronous reset mid-frame: outputs drop to 0 immediately, the FIFO is flushed, and the remainder of the current frame is dropped (prev_fv=1).

Test Plan:
- Reset mid-frame then release with in_fv high -> out_fv stays 0 until in_fv falls and rises again; the next frame with enable=1 passes.
- enable=1, DECIM=2, 7 frames of 10 random-dv pixels -> frames 1, 4, 7 pass; STATUS[15:0]=3; out_data matches in_data delayed by 1 cycle on every out_dv.
- single_shot=1, enable=1, 3 frames -> only frame 1 passes; CTRL reads 0x2 after frame 1 ends.
- During a frame, push (addr 2, 0x1234) and (addr 5, 0xABCD) -> norm_wr_o stays 0 until in_fv=0, then pulses two consecutive cycles with those values in order; FIFO count reads 0 afterwards.
- With in_fv high, push 5 entries at FIFO_DEPTH=4 -> 4 queued; STATUS bit18=1, then 0 on the second STATUS read.
- Write enable=0 mid-frame -> current frame completes intact on out_fv/out_dv; the next frame is blocked.
